// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and pending-destination scoreboard for the 32x32 register file.
// Three producers (ALU=0, LD=1, MD=2) share one registered write port under a
// round-robin grant. A scoreboard of reserved destinations drives the decode
// RAW hazard flags and the WAW issue stall.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_rd_i,
    output logic              iss_ready_o,

    input  logic              alu_valid_i,
    input  logic [AW-1:0]     alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,

    input  logic              ld_valid_i,
    input  logic [AW-1:0]     ld_rd_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,

    input  logic              md_valid_i,
    input  logic [AW-1:0]     md_rd_i,
    input  logic [DATA_W-1:0] md_data_i,
    output logic              md_ready_o,

    input  logic [AW-1:0]     ra_i,
    input  logic [AW-1:0]     rb_i,
    output logic              hazard_a_o,
    output logic              hazard_b_o,

    output logic [AW-1:0]     rf_rw_o,
    output logic [DATA_W-1:0] rf_busw_o,
    output logic              rf_wren_o
);

    localparam int unsigned NReg = 2 ** AW;

    logic [2:0]        req;
    logic [1:0]        ptr_q;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [2:0]        gnt;
    logic [AW-1:0]     gnt_rd;
    logic [DATA_W-1:0] gnt_data;

    logic [AW-1:0]     rf_rw_q;
    logic [DATA_W-1:0] rf_busw_q;
    logic              rf_wren_q;

    logic [NReg-1:0]   pend_q;
    logic [NReg-1:0]   pend_d;
    logic              iss_fire;

    assign req = {md_valid_i, ld_valid_i, alu_valid_i};

    // Round-robin search starting at ptr_q; the first valid requester wins.
    always_comb begin
        logic [1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        idx     = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        gnt = 3'b000;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign alu_ready_o = gnt[0];
    assign ld_ready_o  = gnt[1];
    assign md_ready_o  = gnt[2];

    // Select the granted producer's destination and value.
    always_comb begin
        gnt_rd   = alu_rd_i;
        gnt_data = alu_data_i;
        case (gnt_idx)
            2'd1: begin
                gnt_rd   = ld_rd_i;
                gnt_data = ld_data_i;
            end
            2'd2: begin
                gnt_rd   = md_rd_i;
                gnt_data = md_data_i;
            end
            default: begin
                gnt_rd   = alu_rd_i;
                gnt_data = alu_data_i;
            end
        endcase
    end

    // Pointer advance past the winner and the registered regfile write stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 2'd0;
            rf_rw_q   <= '0;
            rf_busw_q <= '0;
            rf_wren_q <= 1'b0;
        end else if (gnt_any) begin
            ptr_q     <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            rf_rw_q   <= gnt_rd;
            rf_busw_q <= gnt_data;
            // x0 results still consume their slot but never write.
            rf_wren_q <= (gnt_rd != '0);
        end else begin
            rf_wren_q <= 1'b0;
        end
    end

    assign rf_rw_o   = rf_rw_q;
    assign rf_busw_o = rf_busw_q;
    assign rf_wren_o = rf_wren_q;

    assign iss_ready_o = ~pend_q[iss_rd_i];
    assign iss_fire    = iss_valid_i & iss_ready_o;

    // Scoreboard next state: clear on commit, then set, so a new reservation wins.
    always_comb begin
        pend_d = pend_q;
        if (rf_wren_q) begin
            pend_d[rf_rw_q] = 1'b0;
        end
        if (iss_fire && (iss_rd_i != '0)) begin
            pend_d[iss_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign hazard_a_o = pend_q[ra_i];
    assign hazard_b_o = pend_q[rb_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run, all checked against a behavioural model of grants, writes and reservations.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [2:0]  v;
    logic [4:0]  rd [3];
    logic [31:0] dt [3];
    logic [2:0]  rdy;
    logic [4:0]  ra, rb;
    logic        hazard_a, hazard_b;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busw;
    logic        rf_wren;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    int        m_ptr;
    bit [31:0] m_pend;
    bit        m_wren;
    bit [4:0]  m_rw;
    bit [31:0] m_busw;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid_i(iss_valid),
        .iss_rd_i   (iss_rd),
        .iss_ready_o(iss_ready),
        .alu_valid_i(v[0]),
        .alu_rd_i   (rd[0]),
        .alu_data_i (dt[0]),
        .alu_ready_o(rdy[0]),
        .ld_valid_i (v[1]),
        .ld_rd_i    (rd[1]),
        .ld_data_i  (dt[1]),
        .ld_ready_o (rdy[1]),
        .md_valid_i (v[2]),
        .md_rd_i    (rd[2]),
        .md_data_i  (dt[2]),
        .md_ready_o (rdy[2]),
        .ra_i       (ra),
        .rb_i       (rb),
        .hazard_a_o (hazard_a),
        .hazard_b_o (hazard_b),
        .rf_rw_o    (rf_rw),
        .rf_busw_o  (rf_busw),
        .rf_wren_o  (rf_wren)
    );

    function automatic int exp_grant();
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_pend = '0;
        m_wren = 0;
        m_rw   = '0;
        m_busw = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int g;
        bit acc;
        g   = exp_grant();
        acc = iss_valid && !m_pend[iss_rd];
        if (m_wren) m_pend[m_rw] = 1'b0;
        if (acc && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        if (g >= 0) begin
            m_rw   = rd[g];
            m_busw = dt[g];
            m_wren = (rd[g] != 0);
            m_ptr  = (g + 1) % 3;
        end else begin
            m_wren = 0;
        end
    endtask

    task automatic end_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v = 3'b000;
        iss_valid = 1'b0;
        iss_rd = '0;
        ra = '0;
        rb = '0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = '0;
            dt[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        iss_rd = 5'd3;
        ra = 5'd4;
        rb = 5'd4;
        v = 3'b110;
        #3;
        checks++;
        if (rf_wren !== 1'b0 || rf_rw !== 5'd0 || rf_busw !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: got wren=%b rw=%0d busw=%h, expected 0/0/0",
                     rf_wren, rf_rw, rf_busw);
        end
        checks++;
        if (iss_ready !== 1'b1 || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: got iss_ready=%b haz=%b%b, expected 1 00",
                     iss_ready, hazard_a, hazard_b);
        end
        checks++;
        if (rdy !== 3'b010) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 010", rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        v = 3'b001;
        rd[0] = 5'd4;
        dt[0] = 32'hCAFE_0004;
        iss_valid = 1'b1;
        iss_rd = 5'd4;
        ra = 5'd4;
        @(negedge clk);
        end_cycle();
        v = 3'b000;
        iss_valid = 1'b0;
        checks++;
        if (rf_wren !== 1'b1 || hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got wren=%b haz_a=%b expected 1 1", rf_wren, hazard_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_wren !== 1'b0 || rf_rw !== 5'd0 || rf_busw !== 32'd0 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got wren=%b rw=%0d busw=%h haz_a=%b expected 0",
                     rf_wren, rf_rw, rf_busw, hazard_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        v = 3'b111;
        rd[0] = 5'd1;
        rd[1] = 5'd2;
        rd[2] = 5'd3;
        @(negedge clk);
        checks++;
        if (rdy !== 3'b001) begin
            errors++;
            $display("FAIL midreset_ptr: got ready=%b expected 001", rdy);
        end
        v = 3'b000;
        end_cycle();
    endtask

    task automatic test_rotation();
        do_reset();
        v = 3'b111;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 5'(i + 1);
            dt[i] = $urandom;
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (rdy !== 3'(1 << (c % 3))) begin
                errors++;
                $display("FAIL rotation_ready c=%0d: got %b expected %b", c, rdy,
                         3'(1 << (c % 3)));
            end
            if (c > 0) begin
                checks++;
                if (rf_wren !== 1'b1 || rf_rw !== 5'((c - 1) % 3 + 1)
                    || rf_busw !== dt[(c - 1) % 3]) begin
                    errors++;
                    $display("FAIL rotation_write c=%0d: got wren=%b rw=%0d busw=%h expected 1 %0d %h",
                             c, rf_wren, rf_rw, rf_busw, (c - 1) % 3 + 1, dt[(c - 1) % 3]);
                end
            end
            end_cycle();
        end
        v = 3'b000;
        end_cycle();
    endtask

    task automatic test_raw_window();
        do_reset();
        iss_valid = 1'b1;
        iss_rd = 5'd7;
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_issue: got iss_ready=%b expected 1", iss_ready);
        end
        end_cycle();
        iss_valid = 1'b0;
        ra = 5'd7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (hazard_a !== 1'b1) begin
                errors++;
                $display("FAIL raw_hold c=%0d: got hazard_a=%b expected 1", c, hazard_a);
            end
            end_cycle();
        end
        v = 3'b010;
        rd[1] = 5'd7;
        dt[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (rdy !== 3'b010 || hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL raw_c0: got ready=%b hazard_a=%b expected 010 1", rdy, hazard_a);
        end
        end_cycle();
        v = 3'b000;
        @(negedge clk);
        checks++;
        if (rf_wren !== 1'b1 || rf_rw !== 5'd7 || rf_busw !== 32'hDEAD_BEEF || hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL raw_c1: got wren=%b rw=%0d busw=%h haz=%b expected 1 7 deadbeef 1",
                     rf_wren, rf_rw, rf_busw, hazard_a);
        end
        end_cycle();
        @(negedge clk);
        checks++;
        if (hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL raw_c2: got hazard_a=%b expected 0", hazard_a);
        end
        end_cycle();
    endtask

    task automatic test_waw_stall();
        do_reset();
        iss_valid = 1'b1;
        iss_rd = 5'd5;
        @(negedge clk);
        end_cycle();
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: got iss_ready=%b expected 0", iss_ready);
        end
        end_cycle();
        iss_rd = 5'd6;
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_other: got iss_ready=%b expected 1", iss_ready);
        end
        end_cycle();
        iss_rd = 5'd5;
        rb = 5'd6;
        v = 3'b100;
        rd[2] = 5'd5;
        dt[2] = 32'h0000_0555;
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b0 || rdy !== 3'b100 || hazard_b !== 1'b1) begin
            errors++;
            $display("FAIL waw_c0: got iss_ready=%b ready=%b haz_b=%b expected 0 100 1",
                     iss_ready, rdy, hazard_b);
        end
        end_cycle();
        v = 3'b000;
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b0 || rf_wren !== 1'b1) begin
            errors++;
            $display("FAIL waw_c1: got iss_ready=%b wren=%b expected 0 1", iss_ready, rf_wren);
        end
        end_cycle();
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_c2: got iss_ready=%b expected 1", iss_ready);
        end
        end_cycle();
        iss_valid = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        ra = 5'd9;
        v = 3'b001;
        rd[0] = 5'd9;
        dt[0] = 32'h0000_0999;
        @(negedge clk);
        checks++;
        if (rdy !== 3'b001 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL coll_c0: got ready=%b haz_a=%b expected 001 0", rdy, hazard_a);
        end
        end_cycle();
        v = 3'b000;
        iss_valid = 1'b1;
        iss_rd = 5'd9;
        @(negedge clk);
        checks++;
        if (rf_wren !== 1'b1 || rf_rw !== 5'd9 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_c1: got wren=%b rw=%0d iss_ready=%b expected 1 9 1",
                     rf_wren, rf_rw, iss_ready);
        end
        end_cycle();
        iss_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hazard_a !== 1'b1) begin
            errors++;
            $display("FAIL coll_c2: got hazard_a=%b expected 1", hazard_a);
        end
        end_cycle();
    endtask

    task automatic test_x0_idle();
        do_reset();
        v = 3'b001;
        rd[0] = 5'd0;
        dt[0] = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (rdy !== 3'b001) begin
            errors++;
            $display("FAIL x0_grant: got ready=%b expected 001", rdy);
        end
        end_cycle();
        v = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rf_wren !== 1'b0 || rdy !== 3'b000) begin
                errors++;
                $display("FAIL x0_idle c=%0d: got wren=%b ready=%b expected 0 000", c, rf_wren, rdy);
            end
            end_cycle();
        end
        v = 3'b111;
        rd[0] = 5'd1;
        rd[1] = 5'd2;
        rd[2] = 5'd3;
        @(negedge clk);
        checks++;
        if (rdy !== 3'b010) begin
            errors++;
            $display("FAIL x0_ptr: got ready=%b expected 010", rdy);
        end
        end_cycle();
        v = 3'b000;
        end_cycle();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    rd[i] = 5'($urandom_range(0, 15));
                    dt[i] = $urandom;
                end
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = 5'($urandom_range(0, 15));
            ra = 5'($urandom_range(0, 15));
            rb = 5'($urandom_range(0, 15));
            @(negedge clk);
            g = exp_grant();
            checks++;
            if (rdy !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin
                errors++;
                $display("FAIL rand_ready c=%0d: got %b expected grant %0d", c, rdy, g);
            end
            checks++;
            if (iss_ready !== !m_pend[iss_rd] || hazard_a !== m_pend[ra] || hazard_b !== m_pend[rb]) begin
                errors++;
                $display("FAIL rand_sb c=%0d: got iss_ready=%b haz=%b%b expected %b %b%b", c,
                         iss_ready, hazard_a, hazard_b, !m_pend[iss_rd], m_pend[ra], m_pend[rb]);
            end
            checks++;
            if (rf_wren !== m_wren || (m_wren && (rf_rw !== m_rw || rf_busw !== m_busw))) begin
                errors++;
                $display("FAIL rand_write c=%0d: got wren=%b rw=%0d busw=%h expected %b %0d %h",
                         c, rf_wren, rf_rw, rf_busw, m_wren, m_rw, m_busw);
            end
            end_cycle();
            if (g >= 0) v[g] = 1'b0;
        end
        idle_inputs();
        end_cycle();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_rotation();
        test_raw_window();
        test_waw_stall();
        test_collision();
        test_x0_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
